// File: rtl/mode_counter_pkg.sv
// Shared types for the mode counter: counting-mode and FSM-state enums,
// plus the decoder that folds the reserved mode encoding onto wrap.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Encoding 2'b11 is reserved and behaves exactly like wrap.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_SAT;
      2'b10:   return MODE_ONESHOT;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/mode_counter.sv
// Up/down counter with wrap, saturate and one-shot modes, a small
// IDLE/RUN/DONE control FSM, synchronous clear and clamped load.
// Next-state values are formed combinationally and land in one register
// bank; o_busy/o_done are registered copies of the FSM state decode so
// the state is directly observable (IDLE = neither asserted).
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int COUNT_WD = 16
) (
  input  logic                i_clk,
  input  logic                i_rstb,
  input  logic                i_tm_reset,
  input  logic                i_tm_direction,
  input  logic [1:0]          i_mode,
  input  logic                i_en,
  input  logic                i_start,
  input  logic                i_load,
  input  logic [COUNT_WD-1:0] i_load_val,
  input  logic [COUNT_WD-1:0] i_limit,
  output logic [COUNT_WD-1:0] o_count,
  output logic                o_tc,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [COUNT_WD-1:0] ONE  = COUNT_WD'(1);
  localparam logic [COUNT_WD-1:0] ZERO = '0;

  state_e              r_state;
  logic [COUNT_WD-1:0] r_count;
  logic                r_tc;
  logic                r_busy;
  logic                r_done;

  state_e              w_state_nxt;
  logic [COUNT_WD-1:0] w_count_nxt;
  logic                w_tc_nxt;
  mode_e               w_mode;
  logic                w_down;
  logic                w_at_term;
  logic [COUNT_WD-1:0] w_load_clip;
  logic [COUNT_WD-1:0] w_start_val;

  assign w_mode      = decode_mode(i_mode);
  assign w_down      = i_tm_direction;
  // Counting up uses >= so a limit lowered below the count mid-run is
  // caught on the next enabled edge instead of running off to wrap.
  assign w_at_term   = w_down ? (r_count == ZERO) : (r_count >= i_limit);
  assign w_load_clip = (i_load_val > i_limit) ? i_limit : i_load_val;
  assign w_start_val = w_down ? i_limit : ZERO;

  // Next count / state / tc with priority: clear > load > start > step.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    if (i_tm_reset) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = ZERO;
    end else if (i_load) begin
      w_count_nxt = w_load_clip;
    end else if (i_start && (r_state != ST_RUN)) begin
      w_state_nxt = ST_RUN;
      w_count_nxt = w_start_val;
    end else if ((r_state == ST_RUN) && i_en) begin
      if (w_at_term) begin
        w_tc_nxt = 1'b1;
        case (w_mode)
          MODE_SAT: begin
            w_count_nxt = r_count;
          end
          MODE_ONESHOT: begin
            w_count_nxt = r_count;
            w_state_nxt = ST_DONE;
          end
          default: begin
            w_count_nxt = w_start_val;
          end
        endcase
      end else if (w_down) begin
        w_count_nxt = r_count - ONE;
      end else begin
        w_count_nxt = r_count + ONE;
      end
    end
  end

  // Single register bank for count, FSM state and the status flags.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state <= ST_IDLE;
      r_count <= ZERO;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
